// File: rtl/rgb_bank_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module   : rgb_bank_scheduler_if
// Brief    : Host write port and serializer handshake for rgb_bank_scheduler.
// Revision : 1.0
// ============================================================================
interface rgb_bank_scheduler_if #(
  parameter int NUM_BANKS = 4,
  parameter int BANK_W    = 2
);
  logic [255:0]          data_in;
  logic                  data_write_copy;
  logic [7:0]            bank;
  logic                  enable;
  logic                  err_clr;
  logic [255:0]          pix_data;
  logic [BANK_W-1:0]     pix_bank;
  logic                  pix_start;
  logic                  pix_done;
  logic                  frame_done;
  logic [NUM_BANKS-1:0]  pending;
  logic                  err_bank;
  logic                  err_timeout;

  modport master (
    output data_in, data_write_copy, bank, enable, err_clr, pix_done,
    input  pix_data, pix_bank, pix_start, frame_done, pending, err_bank, err_timeout
  );

  modport slave (
    input  data_in, data_write_copy, bank, enable, err_clr, pix_done,
    output pix_data, pix_bank, pix_start, frame_done, pending, err_bank, err_timeout
  );
endinterface
`default_nettype wire

// File: rtl/rgb_bank_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : rgb_bank_scheduler
// Brief    : Shadows per-bank RGB images and hands them round-robin to the
//            LED serializer, followed by a latch gap and frame_done pulse.
// Revision : 1.0
// ============================================================================
module rgb_bank_scheduler #(
  parameter int NUM_BANKS      = 4,
  parameter int BANK_W         = 2,
  parameter int GAP_CYCLES     = 1200,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  wire logic           clk,
  input  wire logic           reset_n,
  rgb_bank_scheduler_if.slave bus_if
);

  localparam int                 C_MAX_CNT   = (GAP_CYCLES > TIMEOUT_CYCLES) ? GAP_CYCLES : TIMEOUT_CYCLES;
  localparam int                 C_CNT_W     = $clog2(C_MAX_CNT + 1);
  localparam logic [C_CNT_W-1:0] C_GAP_LAST  = C_CNT_W'(GAP_CYCLES - 1);
  localparam logic [C_CNT_W-1:0] C_TMO_LAST  = C_CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [8:0]         C_NUM_BANKS = 9'(NUM_BANKS);
  localparam logic [BANK_W-1:0]  C_LAST_BANK = BANK_W'(NUM_BANKS - 1);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_START     = 2'd1,
    S_WAIT_DONE = 2'd2,
    S_GAP       = 2'd3
  } state_t;

  state_t               r_state;
  logic [255:0]         r_shadow [NUM_BANKS];
  logic [NUM_BANKS-1:0] r_pending;
  logic [BANK_W-1:0]    r_ptr;
  logic [BANK_W-1:0]    r_pix_bank;
  logic [255:0]         r_pix_data;
  logic                 r_pix_start;
  logic                 r_frame_done;
  logic                 r_err_bank;
  logic                 r_err_timeout;
  logic [C_CNT_W-1:0]   r_cnt;

  logic                 w_any_pending;
  logic                 w_bank_in_range;
  logic                 w_wr_ok;
  logic                 w_wr_bad;
  logic [BANK_W-1:0]    w_wr_idx;
  logic [BANK_W-1:0]    w_sel;
  logic [BANK_W-1:0]    w_sel_next;
  logic [BANK_W-1:0]    w_cand;
  int                   w_idx;

  assign w_any_pending   = |r_pending;
  assign w_bank_in_range = ({1'b0, bus_if.bank} < C_NUM_BANKS);
  assign w_wr_ok         = bus_if.data_write_copy &&  w_bank_in_range;
  assign w_wr_bad        = bus_if.data_write_copy && !w_bank_in_range;
  assign w_wr_idx        = bus_if.bank[BANK_W-1:0];
  assign w_sel_next      = (w_sel == C_LAST_BANK) ? '0 : (w_sel + BANK_W'(1));

  // Scan offsets from the pointer downward so the nearest pending bank wins.
  always_comb begin
    w_sel  = r_ptr;
    w_idx  = 0;
    w_cand = '0;
    for (int i = NUM_BANKS - 1; i >= 0; i--) begin
      w_idx = int'(r_ptr) + i;
      if (w_idx >= NUM_BANKS) begin
        w_idx = w_idx - NUM_BANKS;
      end
      w_cand = BANK_W'(w_idx);
      if (r_pending[w_cand]) begin
        w_sel = w_cand;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= S_IDLE;
      for (int i = 0; i < NUM_BANKS; i++) begin
        r_shadow[i] <= '0;
      end
      r_pending     <= '0;
      r_ptr         <= '0;
      r_pix_data    <= '0;
      r_pix_bank    <= '0;
      r_pix_start   <= 1'b0;
      r_frame_done  <= 1'b0;
      r_err_bank    <= 1'b0;
      r_err_timeout <= 1'b0;
      r_cnt         <= '0;
    end else begin
      r_pix_start  <= 1'b0;
      r_frame_done <= 1'b0;

      // Clear first so a coincident error event below keeps its flag set.
      if (bus_if.err_clr) begin
        r_err_bank    <= 1'b0;
        r_err_timeout <= 1'b0;
      end

      case (r_state)
        S_IDLE: begin
          if (bus_if.enable && w_any_pending) begin
            r_pix_data         <= r_shadow[w_sel];
            r_pix_bank         <= w_sel;
            r_pending[w_sel]   <= 1'b0;
            r_ptr              <= w_sel_next;
            r_pix_start        <= 1'b1;
            r_state            <= S_START;
          end
        end
        S_START: begin
          r_cnt   <= '0;
          r_state <= S_WAIT_DONE;
        end
        S_WAIT_DONE: begin
          if (bus_if.pix_done) begin
            r_cnt   <= '0;
            r_state <= (bus_if.enable && w_any_pending) ? S_IDLE : S_GAP;
          end else if (r_cnt == C_TMO_LAST) begin
            r_cnt         <= '0;
            r_err_timeout <= 1'b1;
            r_state       <= S_GAP;
          end else begin
            r_cnt <= r_cnt + C_CNT_W'(1);
          end
        end
        S_GAP: begin
          if (r_cnt == C_GAP_LAST) begin
            r_cnt        <= '0;
            r_frame_done <= 1'b1;
            r_state      <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + C_CNT_W'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase

      // A write landing on the bank just selected re-arms it with the new image.
      if (w_wr_ok) begin
        r_shadow[w_wr_idx]  <= bus_if.data_in;
        r_pending[w_wr_idx] <= 1'b1;
      end
      if (w_wr_bad) begin
        r_err_bank <= 1'b1;
      end
    end
  end

  assign bus_if.pix_data    = r_pix_data;
  assign bus_if.pix_bank    = r_pix_bank;
  assign bus_if.pix_start   = r_pix_start;
  assign bus_if.frame_done  = r_frame_done;
  assign bus_if.pending     = r_pending;
  assign bus_if.err_bank    = r_err_bank;
  assign bus_if.err_timeout = r_err_timeout;

endmodule
`default_nettype wire

// File: tb/tb_rgb_bank_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_rgb_bank_scheduler
// Brief    : Scoreboard bench for rgb_bank_scheduler with a transaction model.
// Revision : 1.0
// ============================================================================
module tb_rgb_bank_scheduler;
  localparam int N   = 4;
  localparam int BW  = 2;
  localparam int GAP = 16;
  localparam int TMO = 60;

  localparam int PH_IDLE = 0, PH_START = 1, PH_WAIT = 2, PH_GAP = 3;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  bit   withhold = 1'b0;
  always #5 clk = ~clk;

  rgb_bank_scheduler_if #(.NUM_BANKS(N), .BANK_W(BW)) bif ();

  rgb_bank_scheduler #(
    .NUM_BANKS(N), .BANK_W(BW), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus_if (bif.slave)
  );

  typedef struct {
    int            cyc;
    logic [BW-1:0] bank;
    logic [255:0]  data;
  } xfer_t;

  int checks = 0, errors = 0, cyc = 0, frames_seen = 0;
  xfer_t exp_start[$];
  int    exp_frame[$];
  int    seen_banks[$];
  xfer_t mon_e;

  // Reference model state.
  logic [255:0] m_shadow [N];
  logic [N-1:0] m_pend;
  int           m_ptr, m_phase, m_cnt, m_sel;
  bit           m_eb, m_et, m_to;

  task automatic chk(input string nm, input logic [299:0] act, input logic [299:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  function automatic int first_pending();
    for (int k = 0; k < N; k++) begin
      if (m_pend[(m_ptr + k) % N]) return (m_ptr + k) % N;
    end
    return -1;
  endfunction

  // Transaction-level predictor: what the scheduler must do at each clock edge.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < N; i++) m_shadow[i] = '0;
      m_pend = '0; m_ptr = 0; m_phase = PH_IDLE; m_cnt = 0;
      m_eb = 0; m_et = 0;
      exp_start.delete(); exp_frame.delete();
    end else begin
      cyc++;
      m_to = 0;
      case (m_phase)
        PH_IDLE: if (bif.enable && m_pend != 0) begin
          m_sel = first_pending();
          exp_start.push_back('{cyc, BW'(m_sel), m_shadow[m_sel]});
          m_pend[m_sel] = 1'b0;
          m_ptr = (m_sel + 1) % N;
          m_phase = PH_START;
        end
        PH_START: begin m_phase = PH_WAIT; m_cnt = 0; end
        PH_WAIT: begin
          if (bif.pix_done) begin
            if (bif.enable && m_pend != 0) m_phase = PH_IDLE;
            else begin m_phase = PH_GAP; m_cnt = 0; end
          end else begin
            m_cnt++;
            if (m_cnt == TMO) begin m_to = 1; m_phase = PH_GAP; m_cnt = 0; end
          end
        end
        default: begin
          m_cnt++;
          if (m_cnt == GAP) begin exp_frame.push_back(cyc); m_phase = PH_IDLE; end
        end
      endcase
      if (bif.err_clr) begin m_eb = 0; m_et = 0; end
      if (m_to) m_et = 1;
      if (bif.data_write_copy) begin
        if (int'(bif.bank) < N) begin
          m_shadow[bif.bank[BW-1:0]] = bif.data_in;
          m_pend[bif.bank[BW-1:0]] = 1'b1;
        end else m_eb = 1;
      end
    end
  end

  // Monitor: compares DUT outputs against the scoreboard away from the active edge.
  always @(negedge clk) begin
    if (reset_n) begin
      chk("flags", {bif.pending, bif.err_bank, bif.err_timeout}, {m_pend, m_eb, m_et});
      if (bif.pix_start) begin
        seen_banks.push_back(int'(bif.pix_bank));
        if (exp_start.size() == 0) begin
          checks++; errors++;
          $display("FAIL start_unexpected cyc=%0d bank=%0d required=none", cyc, bif.pix_bank);
        end else begin
          mon_e = exp_start.pop_front();
          chk("start", {cyc, bif.pix_bank, bif.pix_data}, {mon_e.cyc, mon_e.bank, mon_e.data});
        end
      end else if (exp_start.size() != 0 && exp_start[0].cyc <= cyc) begin
        mon_e = exp_start.pop_front();
        checks++; errors++;
        $display("FAIL start_missing actual=none required_cyc=%0d", mon_e.cyc);
      end
      if (bif.frame_done) begin
        frames_seen++;
        if (exp_frame.size() == 0) begin
          checks++; errors++;
          $display("FAIL frame_unexpected cyc=%0d required=none", cyc);
        end else chk("frame_done_cyc", cyc, exp_frame.pop_front());
      end else if (exp_frame.size() != 0 && exp_frame[0] <= cyc) begin
        checks++; errors++;
        $display("FAIL frame_missing actual=none required_cyc=%0d", exp_frame.pop_front());
      end
    end
  end

  // Serializer model: answers each pix_start with pix_done 1..6 cycles later.
  initial begin
    int cnt;
    cnt = 0;
    bif.pix_done = 1'b0;
    forever begin
      @(negedge clk);
      bif.pix_done = 1'b0;
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) bif.pix_done = 1'b1;
      end
      if (!reset_n) cnt = 0;
      else if (bif.pix_start && !withhold) cnt = $urandom_range(1, 6);
    end
  end

  function automatic logic [255:0] rnd256();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom();
    return v;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic write_bank(input logic [7:0] b, input logic [255:0] d);
    bif.bank = b; bif.data_in = d; bif.data_write_copy = 1'b1;
    @(negedge clk);
    bif.data_write_copy = 1'b0;
  endtask

  task automatic wait_start(input int budget, output int n);
    n = 0;
    do begin @(negedge clk); n++; end while (!bif.pix_start && n < budget);
    if (!bif.pix_start) begin
      checks++; errors++;
      $display("FAIL wait_start_timeout actual=none required=pix_start within %0d", budget);
    end
  endtask

  task automatic wait_frame(input int budget);
    int n;
    n = 0;
    do begin @(negedge clk); n++; end while (!bif.frame_done && n < budget);
    if (!bif.frame_done) begin
      checks++; errors++;
      $display("FAIL wait_frame_timeout actual=none required=frame_done within %0d", budget);
    end
  endtask

  task automatic do_reset(input string nm);
    #2 reset_n = 1'b0;
    #1 chk(nm, {bif.pix_data, bif.pix_bank, bif.pix_start, bif.frame_done, bif.pending,
                bif.err_bank, bif.err_timeout}, '0);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    int n, base_frames, base_seen;
    logic [255:0] img_a, img_b;
    bif.data_in = '0; bif.data_write_copy = 1'b0; bif.bank = '0;
    bif.enable = 1'b0; bif.err_clr = 1'b0;
    do_reset("reset_outputs");
    tick(2);

    // Single write to bank 1.
    bif.enable = 1'b1;
    write_bank(8'd1, 256'h1);
    wait_start(10, n);
    chk("single_latency", n, 1);
    chk("single_xfer", {bif.pix_bank, bif.pix_data}, {2'd1, 256'h1});
    wait_frame(TMO + GAP + 20);

    // Round-robin from a fresh pointer.
    do_reset("reset_rr");
    bif.enable = 1'b0;
    write_bank(8'd3, rnd256());
    write_bank(8'd0, rnd256());
    write_bank(8'd2, rnd256());
    seen_banks.delete();
    base_frames = frames_seen;
    bif.enable = 1'b1;
    wait_frame(3 * (TMO + 4) + GAP + 20);
    tick(GAP + 5);
    chk("rr_order", {32'(seen_banks.size()), seen_banks[0], seen_banks[1], seen_banks[2]},
        {32'd3, 32'd0, 32'd2, 32'd3});
    chk("rr_frames", frames_seen - base_frames, 1);

    // Rewrite on the selection edge: old image goes out, bank stays pending.
    img_a = rnd256(); img_b = rnd256();
    write_bank(8'd0, img_a);
    write_bank(8'd0, img_b);
    chk("rewrite_first", {bif.pix_start, bif.pending[0], bif.pix_data}, {1'b1, 1'b1, img_a});
    wait_start(TMO + 10, n);
    chk("rewrite_second", {bif.pix_bank, bif.pix_data}, {2'd0, img_b});
    wait_frame(TMO + GAP + 20);

    // Error flags.
    write_bank(8'h80, rnd256());
    chk("err_bank_set", bif.err_bank, 1);
    withhold = 1'b1;
    write_bank(8'd2, rnd256());
    wait_start(10, n);
    wait_frame(TMO + GAP + 20);
    chk("err_both_set", {bif.err_bank, bif.err_timeout}, 2'b11);
    withhold = 1'b0;
    bif.err_clr = 1'b1;
    @(negedge clk);
    bif.err_clr = 1'b0;
    chk("err_cleared", {bif.err_bank, bif.err_timeout}, 2'b00);

    // Reset in the middle of a transfer.
    withhold = 1'b1;
    write_bank(8'd3, rnd256());
    wait_start(10, n);
    tick(3);
    do_reset("reset_mid_wait");
    withhold = 1'b0;
    base_frames = frames_seen;
    base_seen = seen_banks.size();
    tick(40);
    chk("reset_silent", {32'(frames_seen - base_frames), 32'(seen_banks.size() - base_seen)}, '0);

    // Randomized traffic.
    for (int c = 0; c < 600; c++) begin
      bif.enable = ($urandom_range(0, 9) != 0);
      bif.err_clr = ($urandom_range(0, 49) == 0);
      bif.data_write_copy = ($urandom_range(0, 3) == 0);
      bif.bank = ($urandom_range(0, 15) == 0) ? 8'($urandom_range(4, 255)) : 8'($urandom_range(0, N - 1));
      bif.data_in = rnd256();
      @(negedge clk);
    end
    bif.data_write_copy = 1'b0; bif.err_clr = 1'b0; bif.enable = 1'b1;
    tick(N * 12 + GAP + 60);
    chk("drained", {32'(exp_start.size()), 32'(exp_frame.size())}, '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end
endmodule
`default_nettype wire

// File: doc/rgb_bank_scheduler.md
Name: rgb_bank_scheduler

Overview:
- Sits between the SPI RGB host receiver and the LED-chain serializer.
- Captures each 256-bit bank image on the host's write strobe into per-bank shadow storage and marks the bank pending.
- Hands pending banks round-robin to the serializer over a start/done handshake.
- Inserts a latch gap after each burst, then signals frame completion.

Parameters:
NUM_BANKS, 4, number of bank shadow registers (1..256)
BANK_W, 2, width of bank index, clog2(NUM_BANKS), minimum 1
GAP_CYCLES, 1200, clk cycles of idle latch gap after a burst (at least 1)
TIMEOUT_CYCLES, 65535, max clk cycles waiting for pix_done before abort

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
data_in  in  256  bank image from SPI host
data_write_copy  in  1  single-cycle write strobe, clk domain
bank  in  8  binary bank index qualifying data_write_copy
enable  in  1  allow new serializer transfers
err_clr  in  1  clears sticky error flags
pix_data  out  256  image presented to serializer, stable from pix_start until pix_done
pix_bank  out  BANK_W  bank index of pix_data
pix_start  out  1  one-cycle transfer start pulse
pix_done  in  1  one-cycle serializer completion pulse
frame_done  out  1  one-cycle pulse at end of latch gap
pending  out  NUM_BANKS  per-bank pending flags
err_bank  out  1  sticky: strobe with bank >= NUM_BANKS
err_timeout  out  1  sticky: pix_done not seen within TIMEOUT_CYCLES

Behaviour:
- Reset (async, reset_n=0):
  - All outputs, shadows, pending, round-robin pointer and counters go to 0.
  - State goes to IDLE.
  - Reset mid-transfer abandons it silently; no pix_start or frame_done follows.
- Write path:
  - On data_write_copy with bank < NUM_BANKS, at that edge: shadow[bank] <= data_in and pending[bank] <= 1.
  - On data_write_copy with bank >= NUM_BANKS: no storage change; err_bank <= 1.
  - A repeated write to a pending bank overwrites the shadow; only the latest image is sent.
- State machine, IDLE / START / WAIT_DONE / GAP:
  - IDLE: if enable and any pending bit is set, select the first pending bank searching upward from ptr, wrapping modulo NUM_BANKS. Same edge: pix_data <= shadow[sel], pix_bank <= sel, pending[sel] <= 0, ptr <= (sel+1) mod NUM_BANKS, go to START.
  - START: pix_start = 1 for exactly this cycle; go to WAIT_DONE; clear timeout counter.
  - WAIT_DONE: on pix_done, if enable and any pending, go to IDLE (back-to-back selection, no gap); otherwise go to GAP.
  - WAIT_DONE timeout: if the counter reaches TIMEOUT_CYCLES first, set err_timeout and go to GAP.
  - GAP: count GAP_CYCLES clocks; on the last one pulse frame_done for one cycle and go to IDLE.
- Latency: strobe sampled at edge N; pending visible after N; selection and load at N+1; pix_start high between N+1 and N+2 (when IDLE and enabled).
- Simultaneous write and selection of the same bank:
  - pix_data takes the pre-edge shadow.
  - The set of pending wins over the clear, so pending stays 1 and the new image is sent next.
- enable low: blocks only new selections. An in-flight transfer completes, and GAP and frame_done still occur.
- Ignored inputs: pix_done outside WAIT_DONE is ignored. data_write_copy is accepted in every state.
- pix_data and pix_bank hold their last values until the next selection.
- err_clr clears both sticky flags. If err_clr coincides with a new error event, the error wins (flag stays 1).

Test Plan:
- Reset: assert reset_n=0 mid-WAIT_DONE -> all outputs 0 immediately; after release no pix_start until a new write.
- Single write: bank=1, data_in=256'h1, enable=1 -> pending=4'b0010 for one cycle; pix_start 2 clocks after strobe with pix_bank=1, pix_data=256'h1; pix_done -> frame_done exactly GAP_CYCLES later.
- Round-robin: write banks 3,0,2 with enable=0, then enable=1 and ptr=0 -> order 0,2,3; no gaps between transfers; one frame_done after the third pix_done.
- Rewrite during transfer: write bank 0 = A, start transfer, write bank 0 = B before pix_done -> second transfer sends B; on the coincident select/write edge pending[0] stays 1.
- Errors: strobe with bank=8'h80 -> err_bank=1, no pending change. Withhold pix_done -> err_timeout=1 after TIMEOUT_CYCLES, then frame_done after the gap. err_clr -> both flags 0.
